hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage rv32i core; it is the counterpart of the forwarding unit and handles every hazard forwarding cannot resolve. It detects load-use dependences between the EX-stage load and the ID-stage consumer, freezes the pipeline while instruction or data memory is outstanding, and squashes wrong-path instructions on a taken branch or jump resolved in EX. It drives the PC and pipeline-register load/flush controls and keeps three 32-bit hazard event counters.

## Interface
- No parameters.
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- rs1_ID, rs2_ID  in  rv32i_reg  source registers of the instruction in ID
- use_rs1_ID, use_rs2_ID  in  1  instruction in ID reads rs1 / rs2
- rd_EX  in  rv32i_reg  destination of the instruction in EX
- load_regfile_EX  in  1  instruction in EX writes the regfile
- mem_read_EX  in  1  instruction in EX is a load
- br_taken_EX  in  1  taken branch, jal or jalr resolved in EX
- imem_read, imem_resp  in  1  I-side request / completion
- dmem_req_MEM, dmem_resp  in  1  D-side request (read or write) from MEM / completion
- load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB  out  1  register enables
- flush_IF_ID, flush_ID_EX  out  1  load a bubble (nop, all write enables 0) instead of the next value
- cnt_stall, cnt_bubble, cnt_flush  out  32  memory-stall cycles, load-use bubbles, redirect flushes

## Operation
- mem_busy = (imem_read & ~imem_resp) | (dmem_req_MEM & ~dmem_resp).
- lu_hazard = mem_read_EX & load_regfile_EX & (rd_EX != 0) & ((use_rs1_ID & rs1_ID == rd_EX) | (use_rs2_ID & rs2_ID == rd_EX)).
- FSM states: RUN, BUBBLE, MEM_WAIT.
- Priority is fixed: mem_busy, then br_taken_EX, then lu_hazard.
- Freeze, in any state when mem_busy: all load_* = 0 and all flush_* = 0. Next state is MEM_WAIT. cnt_stall += 1.
- Redirect, when not busy and br_taken_EX: all load_* = 1, flush_IF_ID = flush_ID_EX = 1. Next state is RUN. cnt_flush += 1. A simultaneous lu_hazard is ignored because its instruction is on the wrong path.
- Load-use, in RUN or MEM_WAIT when not busy and lu_hazard:
  - load_pc = load_IF_ID = 0 and flush_ID_EX = 1.
  - load_EX_MEM = load_MEM_WB = 1 and flush_IF_ID = 0.
  - Next state is BUBBLE. cnt_bubble += 1.
- BUBBLE state: lu_hazard is masked for this one cycle, because the bubble now occupies EX. Output is otherwise normal flow. Next state is RUN.
- Normal flow: all load_* = 1, all flush_* = 0. Next state is RUN.
- MEM_WAIT exits the first cycle mem_busy is 0. In that cycle the priority rules above apply; MEM_WAIT does not mask lu_hazard.
- Counters wrap modulo 2^32.

## Timing
- Load and flush outputs are combinational from the state and the current inputs, with zero-cycle latency.
- State and counters update on posedge clk.
- Reset (asynchronous, active-high) puts the state in RUN and clears all counters to 0.
- While rst is high, all load_* = 0 and all flush_* = 0.
- On reset deassertion, operation resumes in RUN on the next edge.
- Reset mid-stall or mid-bubble drops the pending state immediately; no bubble is replayed.
- A load-use bubble costs exactly 1 cycle.
- A redirect costs 2 squashed slots, both issued in the same cycle.
- A memory stall lasts as long as mem_busy is held high; the enables rise in the same cycle the resp arrives.
- br_taken_EX held during a freeze is acted on in the first unfrozen cycle. Because EX is frozen, the input stays valid until then.

## Structure
- Add hazard_state_t (enum RUN, BUBBLE, MEM_WAIT) to the shared rv32i_types package; rv32i_reg comes from the same package.
- One sub-module, hazard_perf_cnt: a 32-bit wrapping counter with clk, rst and inc inputs, instantiated three times.
- The FSM and the output decode live in hazard_ctrl.

## Test plan
- Load-use: EX holds lw x5 with load_regfile_EX=1, mem_read_EX=1, rd_EX=5; ID has rs1_ID=5, use_rs1_ID=1; memory idle.
  - Same cycle: load_pc=0, load_IF_ID=0, flush_ID_EX=1.
  - Next cycle: state BUBBLE, all loads 1, cnt_bubble=1.
- x0 and unused operands:
  - rd_EX=0 with rs1_ID=0 and a load in EX -> no bubble.
  - rs2_ID=5 with use_rs2_ID=0 -> no bubble.
- Simultaneous redirect: br_taken_EX=1 together with a load-use match -> flush_IF_ID=1, flush_ID_EX=1, all loads 1, cnt_flush=1, cnt_bubble=0.
- D-cache miss: dmem_req_MEM=1 with dmem_resp=0 for 4 cycles, then 1.
  - All loads 0 for 4 cycles; loads 1 on the resp cycle.
  - cnt_stall=4.
  - A load-use present throughout fires its bubble on the resp cycle.
- Reset: assert rst asynchronously while in MEM_WAIT with counters nonzero -> all outputs 0 and all counters 0 immediately; state RUN after release.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared rv32i core types: register index and the hazard controller's FSM state.
package rv32i_types;

    typedef logic [4:0] rv32i_reg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BUBBLE   = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// 32-bit wrapping event counter used for the hazard performance statistics.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: memory freeze, EX redirect squash and load-use bubble,
// with combinational pipeline enables and three hazard event counters.
module hazard_ctrl
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  rv32i_reg    rs1_ID,
    input  rv32i_reg    rs2_ID,
    input  logic        use_rs1_ID,
    input  logic        use_rs2_ID,
    input  rv32i_reg    rd_EX,
    input  logic        load_regfile_EX,
    input  logic        mem_read_EX,
    input  logic        br_taken_EX,
    input  logic        imem_read,
    input  logic        imem_resp,
    input  logic        dmem_req_MEM,
    input  logic        dmem_resp,
    output logic        load_pc,
    output logic        load_IF_ID,
    output logic        load_ID_EX,
    output logic        load_EX_MEM,
    output logic        load_MEM_WB,
    output logic        flush_IF_ID,
    output logic        flush_ID_EX,
    output logic [31:0] cnt_stall,
    output logic [31:0] cnt_bubble,
    output logic [31:0] cnt_flush
);

    hazard_state_t state, state_next;
    logic mem_busy, lu_hazard;
    logic inc_stall, inc_bubble, inc_flush;

    assign mem_busy  = (imem_read & ~imem_resp) | (dmem_req_MEM & ~dmem_resp);
    assign lu_hazard = mem_read_EX & load_regfile_EX & (rd_EX != 5'd0) &
                       ((use_rs1_ID & (rs1_ID == rd_EX)) |
                        (use_rs2_ID & (rs2_ID == rd_EX)));

    always_comb begin
        load_pc     = 1'b0;
        load_IF_ID  = 1'b0;
        load_ID_EX  = 1'b0;
        load_EX_MEM = 1'b0;
        load_MEM_WB = 1'b0;
        flush_IF_ID = 1'b0;
        flush_ID_EX = 1'b0;
        inc_stall   = 1'b0;
        inc_bubble  = 1'b0;
        inc_flush   = 1'b0;
        state_next  = state;
        if (rst) begin
            state_next = RUN;
        end else if (mem_busy) begin
            state_next = MEM_WAIT;
            inc_stall  = 1'b1;
        end else if (br_taken_EX) begin
            // Any load-use seen now belongs to the wrong path, so it is dropped.
            {load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB} = 5'b11111;
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
            inc_flush   = 1'b1;
            state_next  = RUN;
        end else if (lu_hazard && state != BUBBLE) begin
            // Hold PC and IF/ID; the consumer re-decodes behind a bubble in EX.
            load_ID_EX  = 1'b1;
            load_EX_MEM = 1'b1;
            load_MEM_WB = 1'b1;
            flush_ID_EX = 1'b1;
            inc_bubble  = 1'b1;
            state_next  = BUBBLE;
        end else begin
            {load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB} = 5'b11111;
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_next;
    end

    hazard_perf_cnt u_cnt_stall  (.clk(clk), .rst(rst), .inc(inc_stall),  .count(cnt_stall));
    hazard_perf_cnt u_cnt_bubble (.clk(clk), .rst(rst), .inc(inc_bubble), .count(cnt_bubble));
    hazard_perf_cnt u_cnt_flush  (.clk(clk), .rst(rst), .inc(inc_flush),  .count(cnt_flush));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios plus random traffic
// against a rule-level reference model.
module tb_hazard_ctrl;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;
    rv32i_reg rs1_ID, rs2_ID, rd_EX;
    logic use_rs1_ID, use_rs2_ID, load_regfile_EX, mem_read_EX, br_taken_EX;
    logic imem_read, imem_resp, dmem_req_MEM, dmem_resp;
    logic load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB;
    logic flush_IF_ID, flush_ID_EX;
    logic [31:0] cnt_stall, cnt_bubble, cnt_flush;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .rd_EX(rd_EX), .load_regfile_EX(load_regfile_EX),
        .mem_read_EX(mem_read_EX), .br_taken_EX(br_taken_EX),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_req_MEM(dmem_req_MEM), .dmem_resp(dmem_resp),
        .load_pc(load_pc), .load_IF_ID(load_IF_ID), .load_ID_EX(load_ID_EX),
        .load_EX_MEM(load_EX_MEM), .load_MEM_WB(load_MEM_WB),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
        .cnt_stall(cnt_stall), .cnt_bubble(cnt_bubble), .cnt_flush(cnt_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic     rst;
        rv32i_reg rs1, rs2, rd;
        logic     use1, use2, load_rf, mem_read, br;
        logic     iread, iresp, dreq, dresp;
    } stim_t;

    typedef struct {
        int          idx;
        logic [6:0]  ctl; // {pc, if_id, id_ex, ex_mem, mem_wb, flush_if_id, flush_id_ex}
        logic [31:0] stall, bubble, flush;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int step_idx = 0;
    bit stim_done = 0;

    // Reference model: counters as plain integers, plus a flag that the previous
    // cycle issued a load-use bubble (which masks the hazard once).
    logic [31:0] m_stall = 0, m_bubble = 0, m_flush = 0;
    bit m_after_bubble = 0;

    task automatic apply(input stim_t s);
        exp_t e;
        bit busy, lu;
        @(posedge clk);
        #1;
        rst = s.rst; rs1_ID = s.rs1; rs2_ID = s.rs2; rd_EX = s.rd;
        use_rs1_ID = s.use1; use_rs2_ID = s.use2; load_regfile_EX = s.load_rf;
        mem_read_EX = s.mem_read; br_taken_EX = s.br;
        imem_read = s.iread; imem_resp = s.iresp; dmem_req_MEM = s.dreq; dmem_resp = s.dresp;

        busy = (s.iread && !s.iresp) || (s.dreq && !s.dresp);
        lu = s.mem_read && s.load_rf && s.rd != 0 &&
             ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
        e.idx = step_idx++;
        if (s.rst) begin
            m_stall = 0; m_bubble = 0; m_flush = 0; m_after_bubble = 0;
            e.ctl = 7'b0;
        end else if (busy) begin
            e.ctl = 7'b0;
        end else if (s.br) begin
            e.ctl = 7'b1111111;
        end else if (lu && !m_after_bubble) begin
            e.ctl = 7'b0011101;
        end else begin
            e.ctl = 7'b1111100;
        end
        e.stall = m_stall; e.bubble = m_bubble; e.flush = m_flush;
        sb.push_back(e);
        // counters advance at the coming edge
        if (!s.rst) begin
            if (busy) begin
                m_stall++; m_after_bubble = 0;
            end else if (s.br) begin
                m_flush++; m_after_bubble = 0;
            end else if (lu && !m_after_bubble) begin
                m_bubble++; m_after_bubble = 1;
            end else begin
                m_after_bubble = 0;
            end
        end
    endtask

    // Monitor: compares mid-cycle, well away from the active edge.
    initial begin
        exp_t e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = {load_pc, load_IF_ID, load_ID_EX, load_EX_MEM, load_MEM_WB,
                       flush_IF_ID, flush_ID_EX};
                checks++;
                if (got !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl step=%0d got=%b want=%b", e.idx, got, e.ctl);
                end
                checks++;
                if (cnt_stall !== e.stall) begin
                    errors++;
                    $display("FAIL cnt_stall step=%0d got=%0d want=%0d", e.idx, cnt_stall, e.stall);
                end
                checks++;
                if (cnt_bubble !== e.bubble) begin
                    errors++;
                    $display("FAIL cnt_bubble step=%0d got=%0d want=%0d", e.idx, cnt_bubble, e.bubble);
                end
                checks++;
                if (cnt_flush !== e.flush) begin
                    errors++;
                    $display("FAIL cnt_flush step=%0d got=%0d want=%0d", e.idx, cnt_flush, e.flush);
                end
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0;
        s.use1 = 0; s.use2 = 0; s.load_rf = 0; s.mem_read = 0; s.br = 0;
        s.iread = 0; s.iresp = 0; s.dreq = 0; s.dresp = 0;
        return s;
    endfunction

    function automatic stim_t lw_x5_use_rs1();
        stim_t s = idle();
        s.mem_read = 1; s.load_rf = 1; s.rd = 5; s.rs1 = 5; s.use1 = 1;
        return s;
    endfunction

    initial begin
        stim_t s;
        int wait_cycles;
        rst = 1;
        rs1_ID = 0; rs2_ID = 0; rd_EX = 0; use_rs1_ID = 0; use_rs2_ID = 0;
        load_regfile_EX = 0; mem_read_EX = 0; br_taken_EX = 0;
        imem_read = 0; imem_resp = 0; dmem_req_MEM = 0; dmem_resp = 0;

        s = idle(); s.rst = 1;
        apply(s); apply(s);
        apply(idle());

        // load-use: bubble now, masked for exactly one cycle, then fires again
        apply(lw_x5_use_rs1());
        apply(lw_x5_use_rs1());
        apply(lw_x5_use_rs1());
        apply(idle());

        // x0 destination never bubbles
        s = lw_x5_use_rs1(); s.rd = 0; s.rs1 = 0;
        apply(s);
        // unused rs2 never bubbles
        s = lw_x5_use_rs1(); s.use1 = 0; s.rs1 = 1; s.rs2 = 5; s.use2 = 0;
        apply(s);
        // used rs2 does
        s.use2 = 1;
        apply(s);
        apply(idle());

        // redirect beats a simultaneous load-use
        s = lw_x5_use_rs1(); s.br = 1;
        apply(s);
        apply(idle());

        // D-side miss for 4 cycles with a pending load-use, bubble on the resp cycle
        s = lw_x5_use_rs1(); s.dreq = 1;
        repeat (4) apply(s);
        s.dresp = 1;
        apply(s);
        apply(idle());

        // branch held through an I-side freeze acts on the first free cycle
        s = idle(); s.br = 1; s.iread = 1;
        repeat (2) apply(s);
        s.iresp = 1;
        apply(s);

        // async reset while stalled with nonzero counters
        s = idle(); s.dreq = 1;
        repeat (2) apply(s);
        s.rst = 1;
        apply(s);
        s = idle();
        apply(s);
        apply(lw_x5_use_rs1());

        // random traffic on a small register range to make matches common
        for (int i = 0; i < 500; i++) begin
            s.rst      = ($urandom_range(0, 99) == 0);
            s.rs1      = rv32i_reg'($urandom_range(0, 3));
            s.rs2      = rv32i_reg'($urandom_range(0, 3));
            s.rd       = rv32i_reg'($urandom_range(0, 3));
            s.use1     = 1'($urandom);
            s.use2     = 1'($urandom);
            s.load_rf  = ($urandom_range(0, 3) != 0);
            s.mem_read = 1'($urandom);
            s.br       = ($urandom_range(0, 7) == 0);
            s.iread    = 1'($urandom);
            s.iresp    = ($urandom_range(0, 3) != 0);
            s.dreq     = 1'($urandom);
            s.dresp    = ($urandom_range(0, 3) != 0);
            apply(s);
        end
        stim_done = 1;

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
